// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the button sequence detector / player pair.
// Latency: none (constants and a pure helper function).
// Backpressure: none.
package seq_pkg;

  localparam int SEQ_LEN = 4;
  localparam int IDX_W   = 2;

  // Unlock code as button numbers, step 0 first: BTN2, BTN3, BTN1, BTN3
  localparam logic [0:SEQ_LEN-1][1:0] SEQ_CODE = {2'd2, 2'd3, 2'd1, 2'd3};

  // Player state encoding; ENTER is only reachable when the enter pulse is built in
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_ENTER = 2'd3;

  // Button number (1..3) to its bit in a [3:1] vector; 0 maps to no button
  function automatic logic [3:1] btn_onehot(input logic [1:0] btn);
    logic [3:1] oh;
    case (btn)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that flags the cycle its count reaches 1.
// Latency: loaded value N gives expired high exactly N cycles after the load edge.
// Backpressure: none; load always wins, the count holds at zero when idle.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and stick at zero
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/seq_player.sv
// seq_player: replays the unlock code on led[3:1] with one-cycle button strobes.
// Latency: start sampled at edge k lights step 0 (led+strobe+busy) in cycle k+1.
// Backpressure: start is ignored while busy; abort returns to IDLE on the next edge.
// Optional feature: define SEQ_PLAYER_ENTER_EN for a one-cycle enter_out after the last gap.
module seq_player
  import seq_pkg::*;
#(
  parameter int ON_CYCLES  = 62500000,
  parameter int GAP_CYCLES = 31250000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:1] led,
  output logic [3:1] strobe,
  output logic       enter_out,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES);

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expired;
  logic             last_step;
  logic [3:1]       led_nxt, strobe_nxt;
  logic             enter_nxt, busy_nxt, done_nxt;

  seq_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .clr_n   (clr_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  assign last_step = (idx == IDX_W'(SEQ_LEN - 1));

  // State and step index registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state, step index and timer reloads
  always_comb begin
    state_nxt = ST_IDLE;
    idx_nxt   = idx;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;
    if (abort) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_ON;
            idx_nxt   = '0;
            tmr_load  = 1'b1;
            tmr_val   = ON_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ON: begin
          if (tmr_expired) begin
            state_nxt = ST_GAP;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LOAD;
          end else begin
            state_nxt = ST_ON;
          end
        end
        ST_GAP: begin
          if (tmr_expired) begin
            if (!last_step) begin
              state_nxt = ST_ON;
              idx_nxt   = idx + IDX_W'(1);
              tmr_load  = 1'b1;
              tmr_val   = ON_LOAD;
            end else begin
`ifdef SEQ_PLAYER_ENTER_EN
              state_nxt = ST_ENTER;
`else
              state_nxt = ST_IDLE;
`endif
            end
          end else begin
            state_nxt = ST_GAP;
          end
        end
`ifdef SEQ_PLAYER_ENTER_EN
        ST_ENTER: state_nxt = ST_IDLE;
`endif
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    led_nxt    = '0;
    strobe_nxt = '0;
    enter_nxt  = 1'b0;
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = 1'b0;
    if (state_nxt == ST_ON) begin
      led_nxt = btn_onehot(SEQ_CODE[idx_nxt]);
    end
    // Strobe only on entry into ON, i.e. the first lit cycle of a step
    if (state_nxt == ST_ON && state != ST_ON) begin
      strobe_nxt = led_nxt;
    end
`ifdef SEQ_PLAYER_ENTER_EN
    enter_nxt = (state_nxt == ST_ENTER);
    done_nxt  = !abort && (state == ST_ENTER);
`else
    done_nxt  = !abort && (state == ST_GAP) && tmr_expired && last_step;
`endif
  end

  // Registered outputs, cleared asynchronously by clr_n
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      led       <= '0;
      strobe    <= '0;
      enter_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      led       <= led_nxt;
      strobe    <= strobe_nxt;
      enter_out <= enter_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed tables plus random start/abort traffic against a run-counter model.
// Latency: checks every output 1 time unit after each rising edge.
// Backpressure: none; the bench drives start/abort freely.
module tb_seq_player;

  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int P   = ON + GAP;
`ifdef SEQ_PLAYER_ENTER_EN
  localparam int TOT = 4 * P + 1;
`else
  localparam int TOT = 4 * P;
`endif

  logic       clk = 1'b0;
  logic       clr_n, start, abort;
  logic [3:1] led, strobe;
  logic       enter_out, busy, done;

  int errors = 0;
  int checks = 0;

  // Model: run_t = position within a run (1..TOT), 0 when idle
  int   run_t    = 0;
  logic exp_done = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:1] led;
    logic [3:1] strobe;
    logic       busy;
    logic       done;
    logic       ent;
  } exp_t;

  exp_t tbl [18];
  logic [3:1] lg_led [32];
  logic [3:1] lg_str [32];
  logic       lg_busy[32];
  logic       lg_done[32];
  logic       lg_ent [32];

  seq_player #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .abort     (abort),
    .led       (led),
    .strobe    (strobe),
    .enter_out (enter_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:1] oh(input int b);
    logic [3:1] r;
    r = 3'b000;
    if (b >= 1 && b <= 3) r[b] = 1'b1;
    return r;
  endfunction

  function automatic int code_at(input int s);
    int c[4] = '{2, 3, 1, 3};
    return c[s];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare every output with what the run position implies
  task automatic check_all(input string tag);
    logic [3:1] el, es;
    logic       ee;
    int         s, ph;
    el = 3'b000; es = 3'b000; ee = 1'b0;
    if (run_t >= 1 && run_t <= 4 * P) begin
      s  = (run_t - 1) / P;
      ph = (run_t - 1) % P;
      if (ph < ON) el = oh(code_at(s));
      if (ph == 0) es = el;
    end
`ifdef SEQ_PLAYER_ENTER_EN
    if (run_t == TOT) ee = 1'b1;
`endif
    chk({tag, "_led"},    int'(led),       int'(el));
    chk({tag, "_strobe"}, int'(strobe),    int'(es));
    chk({tag, "_busy"},   int'(busy),      int'(run_t != 0));
    chk({tag, "_done"},   int'(done),      int'(exp_done));
    chk({tag, "_enter"},  int'(enter_out), int'(ee));
  endtask

  task automatic model_edge(input logic st, input logic ab);
    exp_done = 1'b0;
    if (ab) run_t = 0;
    else if (run_t == 0) begin
      if (st) run_t = 1;
    end else if (run_t == TOT) begin
      run_t    = 0;
      exp_done = 1'b1;
    end else run_t++;
  endtask

  task automatic cyc(input logic st, input logic ab, input string tag);
    start = st;
    abort = ab;
    @(posedge clk);
    model_edge(st, ab);
    #1;
    check_all(tag);
  endtask

  task automatic record(input int i);
    lg_led[i]  = led;
    lg_str[i]  = strobe;
    lg_busy[i] = busy;
    lg_done[i] = done;
    lg_ent[i]  = enter_out;
  endtask

  initial begin
    int saw_done, done_cyc, second_strobe;

    tbl[0]  = '{1,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2,  3'b010, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4,  3'b010, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{5,  3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{6,  3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{7,  3'b100, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{10, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{11, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{13, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{16, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{17, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{19, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{22, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{23, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{24, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
`ifdef SEQ_PLAYER_ENTER_EN
    tbl[15] = '{25, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{26, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
`else
    tbl[15] = '{25, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{26, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
`endif
    tbl[17] = '{28, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};

    // Reset and idle
    clr_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    clr_n = 1'b1;
    repeat (20) cyc(1'b0, 1'b0, "idle");

    // Nominal run, with a start re-pulse at edge 5 that must be ignored
    cyc(1'b1, 1'b0, "nom");
    record(1);
    for (int i = 2; i <= 30; i++) begin
      cyc((i - 1) == 5, 1'b0, "nom");
      record(i);
    end
    for (int k = 0; k < 18; k++) begin
      int c;
      c = tbl[k].cyc;
      chk($sformatf("tbl%0d_led", c),    int'(lg_led[c]),  int'(tbl[k].led));
      chk($sformatf("tbl%0d_strobe", c), int'(lg_str[c]),  int'(tbl[k].strobe));
      chk($sformatf("tbl%0d_busy", c),   int'(lg_busy[c]), int'(tbl[k].busy));
      chk($sformatf("tbl%0d_done", c),   int'(lg_done[c]), int'(tbl[k].done));
      chk($sformatf("tbl%0d_enter", c),  int'(lg_ent[c]),  int'(tbl[k].ent));
    end

    // Abort sampled at edge 9
    cyc(1'b1, 1'b0, "abort_run");
    for (int i = 2; i <= 10; i++) cyc(1'b0, (i - 1) == 9, "abort_run");
    chk("abort_led", int'(led), 0);
    chk("abort_busy", int'(busy), 0);
    saw_done = int'(done);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b0, "abort_after");
      if (done) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    cyc(1'b1, 1'b1, "start_abort");
    chk("start_abort_busy", int'(busy), 0);
    cyc(1'b0, 1'b0, "start_abort_idle");

    // Held start: back-to-back runs with one IDLE (done) cycle between
    done_cyc = 0; second_strobe = 0;
    cyc(1'b1, 1'b0, "held");
    for (int i = 2; i <= TOT + 6; i++) begin
      cyc(1'b1, 1'b0, "held");
      if (done && done_cyc == 0) done_cyc = i;
      if (done_cyc != 0 && i > done_cyc && strobe != 3'b000 && second_strobe == 0)
        second_strobe = i;
    end
    chk("held_done_cycle", done_cyc, TOT + 1);
    chk("held_second_strobe", second_strobe, TOT + 2);
    repeat (TOT + 4) cyc(1'b0, 1'b0, "held_drain");

    // Asynchronous reset during step 2 ON (cycles 13..16)
    cyc(1'b1, 1'b0, "arst_run");
    for (int i = 2; i <= 14; i++) cyc(1'b0, 1'b0, "arst_run");
    #2;
    clr_n = 1'b0;
    #1;
    run_t = 0; exp_done = 1'b0;
    chk("arst_led_async", int'(led), 0);
    chk("arst_busy_async", int'(busy), 0);
    check_all("arst");
    #1;
    clr_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, "arst_idle");
    cyc(1'b1, 1'b0, "restart");
    chk("restart_step0_strobe", int'(strobe), 3'b010);
    repeat (TOT + 2) cyc(1'b0, 1'b0, "restart");

    // Random start/abort traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
